// File: rtl/rename_rat.sv
// rename_rat: speculative RAT plus circular free list feeding the ROB, restored from the retirement RAT on flush
module rename_rat #(
  parameter int AREG_BITS = 5,
  parameter int PREG_BITS = 6,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int ROB_ADDRWIDTH = 4,
  parameter int RENROB_DATAWIDTH = PAYLOAD_WIDTH + 1 + AREG_BITS + 2 * PREG_BITS
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   FREEZE,
  input  logic                                   dec_valid_IN,
  input  logic                                   dec_hasDest_IN,
  input  logic [AREG_BITS-1:0]                   dec_srcA_IN,
  input  logic [AREG_BITS-1:0]                   dec_srcB_IN,
  input  logic [AREG_BITS-1:0]                   dec_dest_IN,
  input  logic [PAYLOAD_WIDTH-1:0]               dec_payload_IN,
  output logic                                   ren_stall_OUT,
  output logic                                   ren_valid_OUT,
  output logic [PREG_BITS-1:0]                   ren_pSrcA_OUT,
  output logic [PREG_BITS-1:0]                   ren_pSrcB_OUT,
  output logic [PREG_BITS-1:0]                   ren_pDest_OUT,
  output logic [ROB_ADDRWIDTH-1:0]               ren_robIdx_OUT,
  output logic                                   tROB_pushReq_OUT,
  output logic [RENROB_DATAWIDTH-1:0]            tROB_pushData_OUT,
  input  logic                                   fROB_full_IN,
  input  logic [ROB_ADDRWIDTH-1:0]               fROB_curTail_IN,
  input  logic                                   com_retire_IN,
  input  logic [PREG_BITS-1:0]                   com_freePreg_IN,
  input  logic                                   flush_IN,
  input  logic [(1<<AREG_BITS)*PREG_BITS-1:0]    retRat_IN
);
  localparam int NUM_AREGS = 1 << AREG_BITS;
  localparam int NUM_PREGS = 1 << PREG_BITS;
  localparam int NFREE = NUM_PREGS - NUM_AREGS;
  localparam int FL_BITS = $clog2(NFREE);
  localparam int PTR_BITS = FL_BITS + 1;
  logic [PREG_BITS-1:0] rat_q [NUM_AREGS];
  logic [PREG_BITS-1:0] fl_q [NFREE];
  logic [PTR_BITS-1:0] spec_head_q, spec_head_d, ret_head_q, ret_head_d, tail_q, tail_d, free_count;
  logic eff_dest, fire, commit, flush;
  logic [PREG_BITS-1:0] p_src_a, p_src_b, p_dest, p_old_dest;
  logic valid_q, push_q;
  logic [PREG_BITS-1:0] src_a_q, src_b_q, dest_q;
  logic [ROB_ADDRWIDTH-1:0] rob_idx_q;
  logic [RENROB_DATAWIDTH-1:0] push_data_q;
  // Lookup, stall decision and pointer next-state; the free count uses registered pointers only
  always_comb begin
    eff_dest = dec_hasDest_IN && (dec_dest_IN != '0);
    free_count = tail_q - spec_head_q;
    ren_stall_OUT = dec_valid_IN && (fROB_full_IN || (eff_dest && free_count == '0) || flush_IN || FREEZE);
    fire = dec_valid_IN && !ren_stall_OUT && RESET;
    commit = com_retire_IN && !FREEZE;
    flush = flush_IN && !FREEZE;
    p_src_a = rat_q[dec_srcA_IN];
    p_src_b = rat_q[dec_srcB_IN];
    p_dest = eff_dest ? fl_q[spec_head_q[FL_BITS-1:0]] : '0;
    p_old_dest = eff_dest ? rat_q[dec_dest_IN] : '0;
    ret_head_d = ret_head_q + PTR_BITS'(commit);
    tail_d = tail_q + PTR_BITS'(commit);
    spec_head_d = flush ? ret_head_d : spec_head_q + PTR_BITS'(fire && eff_dest);
  end
  // Mapping table and free list: commit refills at tail, flush restores, rename allocates at specHead
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_AREGS; i++) rat_q[i] <= PREG_BITS'(i);
      for (int k = 0; k < NFREE; k++) fl_q[k] <= PREG_BITS'(NUM_AREGS + k);
      spec_head_q <= '0;
      ret_head_q <= '0;
      tail_q <= PTR_BITS'(NFREE);
    end else begin
      if (commit) fl_q[tail_q[FL_BITS-1:0]] <= com_freePreg_IN;
      if (flush) begin
        for (int i = 0; i < NUM_AREGS; i++) rat_q[i] <= retRat_IN[i*PREG_BITS +: PREG_BITS];
      end else if (fire && eff_dest) begin
        rat_q[dec_dest_IN] <= p_dest;
      end
      spec_head_q <= spec_head_d;
      ret_head_q <= ret_head_d;
      tail_q <= tail_d;
    end
  end
  // Registered rename results and ROB push; data holds when nothing fires
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      valid_q <= 1'b0;
      push_q <= 1'b0;
      src_a_q <= '0;
      src_b_q <= '0;
      dest_q <= '0;
      rob_idx_q <= '0;
      push_data_q <= '0;
    end else begin
      valid_q <= fire;
      push_q <= fire;
      if (fire) begin
        src_a_q <= p_src_a;
        src_b_q <= p_src_b;
        dest_q <= p_dest;
        rob_idx_q <= fROB_curTail_IN;
        push_data_q <= {dec_payload_IN, eff_dest, dec_dest_IN, p_dest, p_old_dest};
      end
    end
  end
  assign ren_valid_OUT = valid_q;
  assign tROB_pushReq_OUT = push_q;
  assign ren_pSrcA_OUT = src_a_q;
  assign ren_pSrcB_OUT = src_b_q;
  assign ren_pDest_OUT = dest_q;
  assign ren_robIdx_OUT = rob_idx_q;
  assign tROB_pushData_OUT = push_data_q;
endmodule

// File: tb/tb_rename_rat.sv
// tb_rename_rat: randomized rename/commit/flush traffic checked against a counter-based free-list and RAT model
module tb_rename_rat;
  localparam int AB = 5, PB = 6, PW = 32, RB = 4;
  localparam int DW = PW + 1 + AB + 2 * PB;
  localparam int NA = 32, NF = 32;
  logic CLK = 0, RESET = 0, FREEZE = 0;
  logic dec_valid_IN = 0, dec_hasDest_IN = 0;
  logic [AB-1:0] dec_srcA_IN = 0, dec_srcB_IN = 0, dec_dest_IN = 0;
  logic [PW-1:0] dec_payload_IN = 0;
  logic fROB_full_IN = 0, com_retire_IN = 0, flush_IN = 0;
  logic [RB-1:0] fROB_curTail_IN = 0;
  logic [PB-1:0] com_freePreg_IN = 0;
  logic [NA*PB-1:0] retRat_IN = 0;
  logic ren_stall_OUT, ren_valid_OUT, tROB_pushReq_OUT;
  logic [PB-1:0] ren_pSrcA_OUT, ren_pSrcB_OUT, ren_pDest_OUT;
  logic [RB-1:0] ren_robIdx_OUT;
  logic [DW-1:0] tROB_pushData_OUT;
  rename_rat dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
    .dec_valid_IN(dec_valid_IN), .dec_hasDest_IN(dec_hasDest_IN),
    .dec_srcA_IN(dec_srcA_IN), .dec_srcB_IN(dec_srcB_IN), .dec_dest_IN(dec_dest_IN),
    .dec_payload_IN(dec_payload_IN), .ren_stall_OUT(ren_stall_OUT), .ren_valid_OUT(ren_valid_OUT),
    .ren_pSrcA_OUT(ren_pSrcA_OUT), .ren_pSrcB_OUT(ren_pSrcB_OUT), .ren_pDest_OUT(ren_pDest_OUT),
    .ren_robIdx_OUT(ren_robIdx_OUT), .tROB_pushReq_OUT(tROB_pushReq_OUT),
    .tROB_pushData_OUT(tROB_pushData_OUT), .fROB_full_IN(fROB_full_IN),
    .fROB_curTail_IN(fROB_curTail_IN), .com_retire_IN(com_retire_IN),
    .com_freePreg_IN(com_freePreg_IN), .flush_IN(flush_IN), .retRat_IN(retRat_IN)
  );
  always #5 CLK = ~CLK;
  int n_tests = 0, n_fail = 0;
  typedef struct { logic [AB-1:0] a; logic [PB-1:0] p; logic [PB-1:0] o; } ent_t;
  logic [PB-1:0] rat [NA];
  logic [PB-1:0] ret_rat [NA];
  logic [PB-1:0] fl [NF];
  int spec, ret, tail;
  ent_t rob [$];
  logic ev, last_stall = 0;
  logic [PB-1:0] epa, epb, epd, epo;
  logic [RB-1:0] eidx;
  logic [DW-1:0] edata;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      rat[i] = PB'(i);
      ret_rat[i] = PB'(i);
    end
    for (int k = 0; k < NF; k++) fl[k] = PB'(NA + k);
    spec = 0; ret = 0; tail = NF;
    rob.delete();
    ev = 0; epa = 0; epb = 0; epd = 0; epo = 0; eidx = 0; edata = 0;
  endtask
  task automatic cycle();
    logic eff, st, fire, com, fls;
    ent_t e;
    #1;
    eff = dec_hasDest_IN && dec_dest_IN != 0;
    st = dec_valid_IN && (fROB_full_IN || (eff && tail - spec == 0) || flush_IN || FREEZE);
    chk("stall", ren_stall_OUT, st);
    if (!RESET) model_reset();
    else begin
      fire = dec_valid_IN && !st;
      com = com_retire_IN && !FREEZE;
      fls = flush_IN && !FREEZE;
      ev = fire;
      if (fire) begin
        epa = rat[dec_srcA_IN];
        epb = rat[dec_srcB_IN];
        epd = eff ? fl[spec % NF] : '0;
        epo = eff ? rat[dec_dest_IN] : '0;
        eidx = fROB_curTail_IN;
        edata = {dec_payload_IN, eff, dec_dest_IN, epd, epo};
      end
      if (com) begin
        fl[tail % NF] = com_freePreg_IN;
        tail++; ret++;
        e = rob.pop_front();
        ret_rat[e.a] = e.p;
      end
      if (fls) begin
        for (int i = 0; i < NA; i++) rat[i] = retRat_IN[i*PB +: PB];
        spec = ret;
        rob.delete();
      end else if (fire && eff) begin
        rat[dec_dest_IN] = epd;
        spec++;
        rob.push_back('{dec_dest_IN, epd, epo});
      end
    end
    last_stall = st;
    @(posedge CLK);
    @(negedge CLK);
    chk("valid", ren_valid_OUT, ev);
    chk("push", tROB_pushReq_OUT, ev);
    chk("psrca", ren_pSrcA_OUT, epa);
    chk("psrcb", ren_pSrcB_OUT, epb);
    chk("pdest", ren_pDest_OUT, epd);
    chk("robidx", ren_robIdx_OUT, eidx);
    chk("pushdata", tROB_pushData_OUT, edata);
  endtask
  task automatic drive_retrat();
    logic [PB-1:0] rr [NA];
    rr = ret_rat;
    if (com_retire_IN && rob.size() > 0) rr[rob[0].a] = rob[0].p;
    for (int i = 0; i < NA; i++) retRat_IN[i*PB +: PB] = rr[i];
  endtask
  task automatic set_instr(input logic v, input logic h, input int d, input int a, input int b);
    dec_valid_IN = v; dec_hasDest_IN = h;
    dec_dest_IN = AB'(d); dec_srcA_IN = AB'(a); dec_srcB_IN = AB'(b);
    dec_payload_IN = $urandom;
  endtask
  task automatic rnd_inputs();
    if (!(dec_valid_IN && last_stall))
      set_instr($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom, $urandom, $urandom);
    fROB_full_IN = $urandom_range(0, 9) == 0;
    FREEZE = $urandom_range(0, 14) == 0;
    flush_IN = $urandom_range(0, 29) == 0;
    fROB_curTail_IN = RB'($urandom);
    com_retire_IN = rob.size() > 0 && $urandom_range(0, 2) == 0;
    com_freePreg_IN = com_retire_IN ? rob[0].o : PB'($urandom);
    drive_retrat();
  endtask
  initial begin
    model_reset();
    @(negedge CLK);
    repeat (2) cycle();
    RESET = 1;
    set_instr(1, 1, 3, 3, 5);
    cycle();
    chk("t1_pdest", ren_pDest_OUT, 32);
    chk("t1_psrca", ren_pSrcA_OUT, 3);
    chk("t1_pold", tROB_pushData_OUT[PB-1:0], 3);
    set_instr(1, 1, 4, 3, 0);
    cycle();
    chk("t1b_psrca", ren_pSrcA_OUT, 32);
    chk("t1b_pdest", ren_pDest_OUT, 33);
    set_instr(1, 0, 7, 1, 2);
    cycle();
    chk("t3_nodest", ren_pDest_OUT, 0);
    for (int i = 0; i < 32; i++) begin
      set_instr(1, 1, 1 + i % 31, i, i + 1);
      cycle();
    end
    chk("fl_empty_stall", last_stall, 1);
    com_retire_IN = 1;
    com_freePreg_IN = rob[0].o;
    drive_retrat();
    cycle();
    com_retire_IN = 0;
    cycle();
    chk("refill_pdest", ren_pDest_OUT, 3);
    for (int c = 0; c < 4000; c++) begin
      rnd_inputs();
      RESET = c != 2000;
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
